// File: rtl/wb_stage_if.sv
// Upstream result handshake from MEM into the writeback stage.
// A transfer occurs on a rising clk edge when in_valid and in_ready are both 1.
interface wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [2:0]  in_addr_0;
  logic [2:0]  in_addr_1;
  logic [15:0] in_data_0;
  logic [15:0] in_data_1;

  modport master (
    output in_valid, in_mode, in_addr_0, in_addr_1, in_data_0, in_data_1,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_mode, in_addr_0, in_addr_1, in_data_0, in_data_1,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: buffers MEM results in a small FIFO and drains one registered
// dual-port register-file write per cycle, with youngest-wins forwarding lookup.
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  wb_stage_if.slave                  up,
  output logic                       reg_write_en,
  output logic [1:0]                 write_mode,
  output logic [2:0]                 reg_write_addr_0,
  output logic [2:0]                 reg_write_addr_1,
  output logic [15:0]                data_in_0,
  output logic [15:0]                data_in_1,
  input  logic [2:0]                 fwd_addr_0,
  input  logic [2:0]                 fwd_addr_1,
  output logic                       fwd_hit_0,
  output logic                       fwd_hit_1,
  output logic [15:0]                fwd_data_0,
  output logic [15:0]                fwd_data_1,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       idle,
  output logic                       err_bad_mode
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          q_dual [DEPTH];
  logic [2:0]    q_a0   [DEPTH];
  logic [2:0]    q_a1   [DEPTH];
  logic [15:0]   q_d0   [DEPTH];
  logic [15:0]   q_d1   [DEPTH];

  logic full, accept, push, pop, bad, same, n_dual;
  logic [2:0]  n_a1;
  logic [15:0] n_d0, n_d1;

  assign full        = (count == CW'(DEPTH));
  assign up.in_ready = !rst && !full;
  assign accept      = up.in_valid && up.in_ready;
  // Modes 01 and 11 both have bit 0 set; 00 and 10 are consumed without a push.
  assign push        = accept && up.in_mode[0];
  assign bad         = accept && (up.in_mode == 2'b10);
  assign pop         = (count != '0);

  // An equal-address dual write collapses to a single write carrying port 1 data.
  assign same   = (up.in_addr_0 == up.in_addr_1);
  assign n_dual = up.in_mode[1] && !same;
  assign n_d0   = (up.in_mode[1] && same) ? up.in_data_1 : up.in_data_0;
  assign n_a1   = n_dual ? up.in_addr_1 : 3'd0;
  assign n_d1   = n_dual ? up.in_data_1 : 16'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_dual[wr_ptr] <= n_dual;
      q_a0[wr_ptr]   <= up.in_addr_0;
      q_a1[wr_ptr]   <= n_a1;
      q_d0[wr_ptr]   <= n_d0;
      q_d1[wr_ptr]   <= n_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      reg_write_en     <= 1'b0;
      write_mode       <= 2'b00;
      reg_write_addr_0 <= 3'd0;
      reg_write_addr_1 <= 3'd0;
      data_in_0        <= 16'd0;
      data_in_1        <= 16'd0;
      err_bad_mode     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (bad) err_bad_mode <= 1'b1;
      if (pop) begin
        reg_write_en     <= 1'b1;
        write_mode       <= q_dual[rd_ptr] ? 2'b11 : 2'b01;
        reg_write_addr_0 <= q_a0[rd_ptr];
        reg_write_addr_1 <= q_a1[rd_ptr];
        data_in_0        <= q_d0[rd_ptr];
        data_in_1        <= q_d1[rd_ptr];
      end else begin
        reg_write_en <= 1'b0;
        write_mode   <= 2'b00;
      end
    end
  end

  // Lowest priority first so each later match overrides: output register,
  // then FIFO entries oldest to youngest, port 0 before port 1 within an entry.
  function automatic logic [16:0] lookup(input logic [2:0] a);
    logic          hit;
    logic [15:0]   d;
    logic [AW-1:0] idx;
    hit = 1'b0;
    d   = 16'd0;
    if (reg_write_en) begin
      if (reg_write_addr_0 == a) begin hit = 1'b1; d = data_in_0; end
      if (write_mode == 2'b11 && reg_write_addr_1 == a) begin hit = 1'b1; d = data_in_1; end
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (CW'(k) < count) begin
        idx = wr_ptr - AW'(1) - AW'(k);
        if (q_a0[idx] == a) begin hit = 1'b1; d = q_d0[idx]; end
        if (q_dual[idx] && q_a1[idx] == a) begin hit = 1'b1; d = q_d1[idx]; end
      end
    end
    return {hit, d};
  endfunction

  always_comb begin
    {fwd_hit_0, fwd_data_0} = lookup(fwd_addr_0);
    {fwd_hit_1, fwd_data_1} = lookup(fwd_addr_1);
  end

  assign occupancy = count;
  assign idle      = (count == '0) && !reg_write_en;
endmodule
